// File: rtl/muldiv_unit_pkg.sv
// Shared types and funct3 codes for the iterative RV32M multiply/divide unit.
package muldiv_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

endpackage

// File: rtl/muldiv_unit_step.sv
// Combinational radix step: BITS_PER_CYCLE shift-add (mul) or
// restoring shift-subtract (div) iterations on {acc, opnd}.
module muldiv_unit_step #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] acc,
    input  logic [XLEN-1:0] opnd,
    input  logic [XLEN-1:0] oper,
    output logic [XLEN-1:0] acc_next,
    output logic [XLEN-1:0] opnd_next
);

    logic [XLEN:0]   sum;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] q;

    always_comb begin
        a   = acc;
        q   = opnd;
        sum = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (is_div) begin
                // borrow out of the top bit means the trial subtract failed
                sum = {a, q[XLEN-1]} - {1'b0, oper};
                if (sum[XLEN]) begin
                    a = {a[XLEN-2:0], q[XLEN-1]};
                    q = {q[XLEN-2:0], 1'b0};
                end else begin
                    a = sum[XLEN-1:0];
                    q = {q[XLEN-2:0], 1'b1};
                end
            end else begin
                sum = {1'b0, a} + (q[0] ? {1'b0, oper} : {(XLEN+1){1'b0}});
                q   = {sum[0], q[XLEN-1:1]};
                a   = sum[XLEN:1];
            end
        end
        acc_next  = a;
        opnd_next = q;
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage; busy_o stalls the
// front of the pipe while the FSM iterates, done_o strobes the result.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int FAST_SPECIAL   = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [4:0]      rd_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o
);

    localparam int N  = XLEN / BITS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [2:0]        op;
    logic [4:0]        rd;
    logic [XLEN-1:0]   acc, opnd, oper, spec_res;
    logic              neg, special;

    logic [XLEN-1:0]   acc_n, opnd_n;
    logic              accept, s1, s2, neg_now, div_zero, ovf, spec_now;
    logic [XLEN-1:0]   mag1, mag2, spec_val, quo, rem, fin;
    logic [2*XLEN-1:0] prod;

    muldiv_unit_step #(
        .XLEN           (XLEN),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .is_div    (op[2]),
        .acc       (acc),
        .opnd      (opnd),
        .oper      (oper),
        .acc_next  (acc_n),
        .opnd_next (opnd_n)
    );

    assign accept = start_i & ~flush_i & (state == IDLE || state == DONE);
    assign busy_o = (state == CALC);
    assign done_o = (state == DONE) & ~flush_i;

    always_comb begin
        s1 = rs1_i[XLEN-1] & ~(op_i == MD_MUL || op_i == MD_MULHU ||
                               op_i == MD_DIVU || op_i == MD_REMU);
        s2 = rs2_i[XLEN-1] & (op_i == MD_MULH || op_i == MD_DIV ||
                              op_i == MD_REM);
        mag1 = s1 ? -rs1_i : rs1_i;
        mag2 = s2 ? -rs2_i : rs2_i;
        // remainder takes the dividend's sign, everything else the xor
        neg_now  = (op_i == MD_REM) ? s1 : (s1 ^ s2);
        div_zero = op_i[2] && (rs2_i == '0);
        ovf      = (op_i == MD_DIV || op_i == MD_REM) &&
                   (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (&rs2_i);
        spec_now = div_zero | ovf;
        if (op_i[1])
            spec_val = div_zero ? rs1_i : '0;
        else
            spec_val = div_zero ? '1 : rs1_i;
    end

    always_comb begin
        prod = {acc_n, opnd_n};
        if (neg)
            prod = -prod;
        quo = neg ? -opnd_n : opnd_n;
        rem = neg ? -acc_n : acc_n;
        if (special)
            fin = spec_res;
        else if (op == MD_MUL)
            fin = prod[XLEN-1:0];
        else if (!op[2])
            fin = prod[2*XLEN-1:XLEN];
        else if (op[1])
            fin = rem;
        else
            fin = quo;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            op       <= '0;
            rd       <= '0;
            acc      <= '0;
            opnd     <= '0;
            oper     <= '0;
            spec_res <= '0;
            neg      <= 1'b0;
            special  <= 1'b0;
            result_o <= '0;
            rd_o     <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        op       <= op_i;
                        rd       <= rd_i;
                        neg      <= neg_now;
                        special  <= spec_now;
                        spec_res <= spec_val;
                        acc      <= '0;
                        opnd     <= op_i[2] ? mag1 : mag2;
                        oper     <= op_i[2] ? mag2 : mag1;
                        cnt      <= CW'(N - 1);
                        if (spec_now && FAST_SPECIAL != 0) begin
                            state    <= DONE;
                            result_o <= spec_val;
                            rd_o     <= rd_i;
                        end else begin
                            state <= CALC;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    if (flush_i) begin
                        state <= IDLE;
                    end else begin
                        acc  <= acc_n;
                        opnd <= opnd_n;
                        cnt  <= cnt - 1'b1;
                        if (cnt == '0) begin
                            state    <= DONE;
                            result_o <= fin;
                            rd_o     <= rd;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
